// File: rtl/e_reg_if.sv
// Decode->Execute register bundle: decode results and hazard inputs in, E fields,
// F/D hazard controls and bubble performance counters out.
interface e_reg_if #(parameter int CNT_W = 32);
  logic [2:0]       d_stat;
  logic [3:0]       d_icode, d_ifun;
  logic [63:0]      d_valC, d_valA, d_valB;
  logic [3:0]       d_dstE, d_dstM, d_srcA, d_srcB;
  logic [3:0]       D_icode, M_icode;
  logic             e_Cnd;
  logic             ext_stall;

  logic [2:0]       E_stat;
  logic [3:0]       E_icode, E_ifun;
  logic [63:0]      E_valC, E_valA, E_valB;
  logic [3:0]       E_dstE, E_dstM, E_srcA, E_srcB;
  logic             F_stall, D_stall, D_bubble;
  logic [CNT_W-1:0] bubble_cnt, loaduse_cnt;

  modport slave (
    input  d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
           d_dstE, d_dstM, d_srcA, d_srcB, D_icode, M_icode, e_Cnd, ext_stall,
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB, F_stall, D_stall, D_bubble,
           bubble_cnt, loaduse_cnt
  );

  modport master (
    output d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
           d_dstE, d_dstM, d_srcA, d_srcB, D_icode, M_icode, e_Cnd, ext_stall,
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB, F_stall, D_stall, D_bubble,
           bubble_cnt, loaduse_cnt
  );
endinterface

// File: rtl/e_reg.sv
// Y86-64 Decode->Execute register with load/use, mispredict and ret hazard control; 1-cycle latency.
// ext_stall freezes E and the counters; F/D controls are combinational and left ungated by ext_stall.
module e_reg #(
  parameter int CNT_W = 32
) (
  input logic  clk,
  input logic  rst_n,
  e_reg_if.slave bus
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } e_t;

  // Bubble carries stat=AOK so a squashed fault never reaches execute.
  localparam e_t BUBBLE = '{stat: 3'd1, icode: I_NOP, ifun: 4'd0,
                            valC: 64'd0, valA: 64'd0, valB: 64'd0,
                            dstE: R_NONE, dstM: R_NONE, srcA: R_NONE, srcB: R_NONE};

  e_t               e_q, e_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] loaduse_cnt_q, loaduse_cnt_d;
  logic             lu, mp, rt, e_bubble;

  always_comb begin
    lu = ((e_q.icode == I_MRMOVQ) || (e_q.icode == I_POPQ)) &&
         (e_q.dstM != R_NONE) &&
         ((e_q.dstM == bus.d_srcA) || (e_q.dstM == bus.d_srcB));
    mp = (e_q.icode == I_JXX) && !bus.e_Cnd;
    rt = (bus.D_icode == I_RET) || (e_q.icode == I_RET) || (bus.M_icode == I_RET);
    e_bubble = mp | lu;
  end

  assign bus.F_stall  = rst_n & (lu | rt);
  assign bus.D_stall  = rst_n & lu;
  assign bus.D_bubble = rst_n & (mp | (rt & ~lu));

  always_comb begin
    e_d           = e_q;
    bubble_cnt_d  = bubble_cnt_q;
    loaduse_cnt_d = loaduse_cnt_q;
    if (!bus.ext_stall) begin
      if (e_bubble) begin
        e_d = BUBBLE;
        if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
      end else begin
        e_d = '{stat: bus.d_stat, icode: bus.d_icode, ifun: bus.d_ifun,
                valC: bus.d_valC, valA: bus.d_valA, valB: bus.d_valB,
                dstE: bus.d_dstE, dstM: bus.d_dstM, srcA: bus.d_srcA, srcB: bus.d_srcB};
      end
      if (lu && (loaduse_cnt_q != '1)) loaduse_cnt_d = loaduse_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q           <= BUBBLE;
      bubble_cnt_q  <= '0;
      loaduse_cnt_q <= '0;
    end else begin
      e_q           <= e_d;
      bubble_cnt_q  <= bubble_cnt_d;
      loaduse_cnt_q <= loaduse_cnt_d;
    end
  end

  assign bus.E_stat      = e_q.stat;
  assign bus.E_icode     = e_q.icode;
  assign bus.E_ifun      = e_q.ifun;
  assign bus.E_valC      = e_q.valC;
  assign bus.E_valA      = e_q.valA;
  assign bus.E_valB      = e_q.valB;
  assign bus.E_dstE      = e_q.dstE;
  assign bus.E_dstM      = e_q.dstM;
  assign bus.E_srcA      = e_q.srcA;
  assign bus.E_srcB      = e_q.srcB;
  assign bus.bubble_cnt  = bubble_cnt_q;
  assign bus.loaduse_cnt = loaduse_cnt_q;

endmodule
